fetch_sequencer: RTL

- Controls instruction fetch for the SIMD pipeline: owns the 6-bit PC and drives the address of the 64x25 instruction memory.
- Registers each fetched word into the IF/ID stage register with a valid/ready handshake to decode.
- Supports decode back-pressure (stall), redirect/flush, and a bounded program run with a completion pulse.
- Sits between the instruction memory and the decode stage.

---
 rtl/fetch_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch control for the SIMD pipeline.
// Owns the PC, addresses the 64-entry instruction memory, and keeps the
// IF/ID stage register with a valid/ready handshake toward decode.
// A run fetches PCs 0..len-1 unless redirected, then pulses done once.
module fetch_sequencer #(
  parameter int PC_W    = 6,
  parameter int INSTR_W = 25,
  parameter int LEN_W   = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LEN_W-1:0]   prog_len,
  output logic [PC_W-1:0]    mem_addr,
  input  logic [INSTR_W-1:0] mem_data,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               busy,
  output logic               done,
  output logic [LEN_W-1:0]   fetch_count
);

  // Number of memory entries; also the clamp for prog_len and fetch_count.
  localparam logic [LEN_W-1:0] DEPTH = LEN_W'(2 ** PC_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  // Current state registers.
  state_t             state;
  logic [PC_W-1:0]    pc;
  logic [LEN_W-1:0]   len_q;

  // Next-state values computed by the combinational process.
  state_t             state_n;
  logic [PC_W-1:0]    pc_n;
  logic [LEN_W-1:0]   len_n;
  logic               valid_n;
  logic [INSTR_W-1:0] instr_n;
  logic [PC_W-1:0]    id_pc_n;
  logic [LEN_W-1:0]   count_n;

  // Decoded events for the current cycle.
  logic               handshake;
  logic               adv;
  logic               redirect;
  logic               last_pc;
  logic               redirect_in_range;
  logic [LEN_W-1:0]   len_clamped;

  // The memory is addressed straight from the PC; status is decoded from state.
  assign mem_addr = pc;
  assign busy     = (state == S_FETCH) || (state == S_DRAIN);
  assign done     = (state == S_DONE);

  // Cycle events: a decode acceptance, a new fetch into IF/ID, and a live redirect.
  assign handshake         = id_valid && id_ready;
  assign adv               = (state == S_FETCH) && (!id_valid || id_ready) && !redirect_valid;
  assign redirect          = redirect_valid && busy;
  assign last_pc           = (LEN_W'(pc) == len_q - LEN_W'(1));
  assign redirect_in_range = (LEN_W'(redirect_pc) < len_q);
  assign len_clamped       = (prog_len > DEPTH) ? DEPTH : prog_len;

  // Next-state and next-datapath logic for the fetch FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    state_n = state;
    pc_n    = pc;
    len_n   = len_q;
    valid_n = id_valid;
    instr_n = id_instr;
    id_pc_n = id_pc;
    count_n = fetch_count;

    // Accepted instructions are counted unless squashed by a redirect.
    if (handshake && !redirect_valid && (fetch_count != DEPTH)) begin
      count_n = fetch_count + LEN_W'(1);
    end

    unique case (state)
      S_IDLE: begin
        if (start) begin
          len_n   = len_clamped;
          pc_n    = '0;
          count_n = '0;
          state_n = (len_clamped == '0) ? S_DONE : S_FETCH;
        end
      end

      S_FETCH: begin
        if (redirect) begin
          // Squash whatever sits in IF/ID and restart or end the run.
          valid_n = 1'b0;
          if (redirect_in_range) begin
            pc_n    = redirect_pc;
            state_n = S_FETCH;
          end else begin
            state_n = S_DONE;
          end
        end else if (adv) begin
          instr_n = mem_data;
          id_pc_n = pc;
          valid_n = 1'b1;
          // The final PC is held rather than incremented, so 63 never wraps.
          if (last_pc) begin
            state_n = S_DRAIN;
          end else begin
            pc_n = pc + PC_W'(1);
          end
        end else if (handshake) begin
          valid_n = 1'b0;
        end
      end

      S_DRAIN: begin
        if (redirect) begin
          valid_n = 1'b0;
          if (redirect_in_range) begin
            pc_n    = redirect_pc;
            state_n = S_FETCH;
          end else begin
            state_n = S_DONE;
          end
        end else if (!id_valid || handshake) begin
          // The last instruction has left IF/ID; finish the run.
          valid_n = 1'b0;
          state_n = S_DONE;
        end
      end

      S_DONE: begin
        // done is high for this single cycle; any start here is ignored.
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State and IF/ID register update with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      len_q       <= '0;
      id_valid    <= 1'b0;
      id_instr    <= '0;
      id_pc       <= '0;
      fetch_count <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      len_q       <= len_n;
      id_valid    <= valid_n;
      id_instr    <= instr_n;
      id_pc       <= id_pc_n;
      fetch_count <= count_n;
    end
  end

endmodule
